// File: rtl/fetch_queue.sv
// Instruction fetch unit with a DEPTH-entry prefetch queue between memory and decode.
// Define FETCH_QUEUE_RVC_EN to enable halfword realignment for compressed/unaligned opcodes.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clk_ce,
  output logic [31:0]                o_mem_addr,
  output logic                       o_mem_req,
  input  logic                       i_mem_ack,
  input  logic [31:0]                i_mem_data,
  input  logic                       i_hz_data,
  input  logic                       i_br_en,
  input  logic [31:0]                i_br_addr,
  output logic [31:0]                o_if_pc,
  output logic [31:0]                o_id_pc,
  output logic [31:0]                o_id_ir,
  output logic [31:0]                o_id_ret,
  output logic                       o_hz_br,
  output logic [$clog2(DEPTH):0]     o_q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   q_pc [DEPTH];
  logic [31:0]   q_ir [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic [31:0]   fpc;

  logic [31:0]   head_pc, head_ir;
  logic          avail;
  logic          push, pop, free;
  logic [31:0]   id_pc_raw, id_ir_raw, id_ret_raw;
  logic [31:0]   br_target;

  assign head_pc    = q_pc[rptr];
  assign head_ir    = q_ir[rptr];
  assign o_mem_req  = (count < FULL);
  assign o_mem_addr = {fpc[31:2], 2'b00};
  assign o_if_pc    = fpc;
  assign o_q_count  = count;

  assign push = i_clk_ce && o_mem_req && i_mem_ack && !i_br_en;
  assign pop  = i_clk_ce && avail && !i_hz_data && !i_br_en;

`ifdef FETCH_QUEUE_RVC_EN
  logic        hoff;
  logic [31:0] next_ir;
  logic [15:0] half;
  logic        is_c;
  logic        unused_rvc;

  assign next_ir    = q_ir[rptr + AW'(1)];
  assign br_target  = {i_br_addr[31:1], 1'b0};
  assign unused_rvc = &{1'b0, i_br_addr[0], next_ir[31:16]};

  // A 32-bit opcode starting in the upper half needs the following entry too.
  always_comb begin
    half       = hoff ? head_ir[31:16] : head_ir[15:0];
    is_c       = (half[1:0] != 2'b11);
    avail      = (count != '0) && (is_c || !hoff || (count >= CW'(2)));
    id_pc_raw  = head_pc + {30'd0, hoff, 1'b0};
    id_ir_raw  = head_ir;
    if (is_c)
      id_ir_raw = {16'h0000, half};
    else if (hoff)
      id_ir_raw = {next_ir[15:0], head_ir[31:16]};
    id_ret_raw = id_pc_raw + (is_c ? 32'd2 : 32'd4);
    // The head entry is released once its upper half has been consumed.
    free       = pop && (hoff || !is_c);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      hoff <= 1'b0;
    else if (i_clk_ce) begin
      if (i_br_en)
        hoff <= i_br_addr[1];
      else if (pop)
        hoff <= hoff ^ is_c;
    end
  end
`else
  logic unused_br;

  assign br_target = {i_br_addr[31:2], 2'b00};
  assign unused_br = &{1'b0, i_br_addr[1:0]};

  always_comb begin
    avail      = (count != '0);
    id_pc_raw  = head_pc;
    id_ir_raw  = head_ir;
    id_ret_raw = head_pc + 32'd4;
    free       = pop;
  end
`endif

  assign o_hz_br  = !avail;
  assign o_id_pc  = avail ? id_pc_raw  : '0;
  assign o_id_ir  = avail ? id_ir_raw  : '0;
  assign o_id_ret = avail ? id_ret_raw : '0;

  always_ff @(posedge i_clk) begin
    if (push) begin
      q_pc[wptr] <= o_mem_addr;
      q_ir[wptr] <= i_mem_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
`ifdef FETCH_QUEUE_RVC_EN
      fpc <= {RESET_PC[31:1], 1'b0};
`else
      fpc <= {RESET_PC[31:2], 2'b00};
`endif
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
    end else if (i_clk_ce) begin
      if (i_br_en) begin
        fpc   <= br_target;
        count <= '0;
        rptr  <= '0;
        wptr  <= '0;
      end else begin
        if (push) begin
          wptr <= wptr + AW'(1);
          fpc  <= fpc + 32'd4;
        end
        if (free)
          rptr <= rptr + AW'(1);
        case ({push, free})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4) with a combinational memory model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, ce, ack, hz, br;
  logic [31:0] br_addr, mem_data;
  logic [31:0] mem_addr, if_pc, id_pc, id_ir, id_ret;
  logic        mem_req, hz_br;
  logic [2:0]  q_count;
  logic        rvc_mem = 1'b0;

  int unsigned npass  = 0;
  int unsigned ntotal = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h00000000)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clk_ce   (ce),
    .o_mem_addr (mem_addr),
    .o_mem_req  (mem_req),
    .i_mem_ack  (ack),
    .i_mem_data (mem_data),
    .i_hz_data  (hz),
    .i_br_en    (br),
    .i_br_addr  (br_addr),
    .o_if_pc    (if_pc),
    .o_id_pc    (id_pc),
    .o_id_ir    (id_ir),
    .o_id_ret   (id_ret),
    .o_hz_br    (hz_br),
    .o_q_count  (q_count)
  );

  always #5 clk = ~clk;

  // Words are "addi x1,x0,n" style: immediate = word index; word 0 is a plain NOP.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic rvc);
    if (rvc && a == 32'h100) return 32'h00010001;
    if (rvc && a == 32'h104) return 32'h05130001;
    if (rvc && a == 32'h108) return 32'h000100A0;
    if (a == 32'h0) return 32'h00000013;
    return {a[13:2], 20'h00093};
  endfunction

  always_comb mem_data = mem_word(mem_addr, rvc_mem);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; ack = 1'b0; hz = 1'b0; br = 1'b0; br_addr = '0;
    step(); step();
    rst = 1'b0;

    // reset state
    check("rst_hz_br", 32'(hz_br), 32'd1);
    check("rst_count", 32'(q_count), 32'd0);
    check("rst_ir", id_ir, 32'h0);
    check("rst_pc", id_pc, 32'h0);
    check("rst_ret", id_ret, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_req", 32'(mem_req), 32'd1);

    // streaming: ack every cycle, no stall
    ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("stream_pc", id_pc, 32'(4 * k));
      check("stream_ir", id_ir, mem_word(32'(4 * k), 1'b0));
      check("stream_ret", id_ret, 32'(4 * k + 4));
      check("stream_hz_br", 32'(hz_br), 32'd0);
      check("stream_count", 32'(q_count), 32'd1);
    end

    // stall fills the queue; then drain with no bubble
    hz = 1'b1;
    repeat (6) step();
    check("full_count", 32'(q_count), 32'd4);
    check("full_req", 32'(mem_req), 32'd0);
    check("full_if_pc", if_pc, 32'h2C);
    check("full_head", id_pc, 32'h1C);
    hz = 1'b0; ack = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check("drain_pc", id_pc, 32'(32'h1C + 4 * j));
      check("drain_count", 32'(q_count), 32'(4 - j));
      check("drain_hz_br", 32'(hz_br), 32'd0);
      step();
    end
    check("drained_hz_br", 32'(hz_br), 32'd1);
    check("drained_count", 32'(q_count), 32'd0);
    check("drained_ir", id_ir, 32'h0);

    // sparse acks: one word every third cycle
    for (int n = 0; n < 4; n++) begin
      check("sparse_gap_a", 32'(hz_br), 32'd1);
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("sparse_pc", id_pc, 32'(32'h2C + 4 * n));
      check("sparse_hz_br", 32'(hz_br), 32'd0);
      step();
      check("sparse_gap_c", 32'(hz_br), 32'd1);
      step();
    end

    // branch flush with 3 entries queued and ack high
    hz = 1'b1; ack = 1'b1;
    repeat (3) step();
    check("prebr_count", 32'(q_count), 32'd3);
    check("prebr_head", id_pc, 32'h3C);
    br = 1'b1; br_addr = 32'h100;
    step();
    br = 1'b0; hz = 1'b0;
    check("br_count", 32'(q_count), 32'd0);
    check("br_mem_addr", mem_addr, 32'h100);
    check("br_if_pc", if_pc, 32'h100);
    check("br_hz_br", 32'(hz_br), 32'd1);
    check("br_ir_empty", id_ir, 32'h0);
    step();
    check("br_tgt_pc", id_pc, 32'h100);
    check("br_tgt_ir", id_ir, mem_word(32'h100, 1'b0));
    step();
    check("br_next_pc", id_pc, 32'h104);

    // clock enable low: everything frozen despite acks
    ce = 1'b0;
    for (int f = 0; f < 5; f++) begin
      step();
      check("ce_pc", id_pc, 32'h104);
      check("ce_count", 32'(q_count), 32'd1);
      check("ce_if_pc", if_pc, 32'h108);
    end
    ce = 1'b1;
    step();
    check("ce_resume_pc", id_pc, 32'h108);
    check("ce_resume_ir", id_ir, mem_word(32'h108, 1'b0));
    step();
    check("ce_resume_pc2", id_pc, 32'h10C);

`ifndef FETCH_QUEUE_RVC_EN
    // branch target low bits are dropped in word-only builds
    br = 1'b1; br_addr = 32'h203; ack = 1'b0;
    step();
    br = 1'b0;
    check("br_align_if_pc", if_pc, 32'h200);
    check("br_align_mem", mem_addr, 32'h200);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("br_align_pc", id_pc, 32'h200);
`endif

    // reset wins over a low clock enable
    ce = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; ce = 1'b1; ack = 1'b0;
    check("rst_ce_count", 32'(q_count), 32'd0);
    check("rst_ce_if_pc", if_pc, 32'h0);
    check("rst_ce_hz_br", 32'(hz_br), 32'd1);

`ifdef FETCH_QUEUE_RVC_EN
    rvc_mem = 1'b1;
    br = 1'b1; br_addr = 32'h102;
    step();
    br = 1'b0;
    check("rvc_br_mem", mem_addr, 32'h100);
    check("rvc_br_hz", 32'(hz_br), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("rvc_c0_pc", id_pc, 32'h102);
    check("rvc_c0_ir", id_ir, 32'h00000001);
    check("rvc_c0_ret", id_ret, 32'h104);
    step();
    check("rvc_empty", 32'(hz_br), 32'd1);
    check("rvc_empty_cnt", 32'(q_count), 32'd0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("rvc_c1_pc", id_pc, 32'h104);
    check("rvc_c1_ir", id_ir, 32'h00000001);
    check("rvc_c1_ret", id_ret, 32'h106);
    step();
    check("rvc_wait_hz", 32'(hz_br), 32'd1);
    check("rvc_wait_cnt", 32'(q_count), 32'd1);
    check("rvc_wait_ir", id_ir, 32'h0);
    step();
    check("rvc_wait2_hz", 32'(hz_br), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("rvc_w_pc", id_pc, 32'h106);
    check("rvc_w_ir", id_ir, 32'h00A00513);
    check("rvc_w_ret", id_ret, 32'h10A);
    step();
    check("rvc_c2_pc", id_pc, 32'h10A);
    check("rvc_c2_ir", id_ir, 32'h00000001);
    check("rvc_c2_ret", id_ret, 32'h10C);
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
